bcd_updown_counter: RTL
=======================

// Module: bcd_updown_counter
// PURPOSE
//   Multi-digit synchronous BCD counter with parallel load, up/down mode, count
//   enable and a wrap flag. It is the parametrised successor of the fixed 4-bit
//   loadable sequence counter. Packed BCD output drives hex_7seg digits
//   directly, one nibble per display, so no binary_to_BCD stage is needed.
//   Load, enable and mode come from debounced KEY/SW inputs at top level.
// PARAMETERS
//   DIGITS     3   number of BCD digits; count range 0 .. 10^DIGITS-1
//   RESET_VAL  0   packed-BCD value loaded by reset, 4*DIGITS bits wide
//                  (each nibble must be 0..9)
// PORTS
//   clk        in   1          counter clock, all state changes on posedge
//   rst_n      in   1          reset, synchronous, active-low
//   load       in   1          active-high parallel load of din
//   din        in   4*DIGITS   packed-BCD load value, digit 0 in [3:0]
//   en         in   1          count enable, one step per clk edge when high
//   up         in   1          1 = count up, 0 = count down
//   q          out  4*DIGITS   current count, packed BCD
//   tc         out  1          terminal count, combinational:
//                              up:   en & q==all 9s
//                              down: en & q==0
//   wrap       out  1          registered 1-cycle pulse: a wrap occurred on
//                              the previous edge
// BEHAVIOUR
//   - Single clock domain. Reset is synchronous and active-low: sampled on
//     posedge clk only.
//   - Priority per edge: rst_n==0 > load > en > hold.
//   - Reset: q <= RESET_VAL, wrap <= 0. tc follows q and en combinationally.
//   - Load: each din nibble >9 is clamped to 9; q <= clamped din; wrap <= 0.
//     Load beats en when both are high; no count occurs that cycle.
//   - Count up: digit 0 +1. A digit at 9 goes to 0 and carries into the next
//     digit; carry ripples within the same cycle, giving single-cycle latency.
//   - Count down: digit 0 -1. A digit at 0 goes to 9 and borrows from the
//     next digit.
//   - Wrap-around: up from all 9s gives 0; down from 0 gives all 9s.
//     wrap <= 1 for exactly the next cycle; otherwise wrap <= 0 every edge.
//   - Hold (en==0, load==0): q unchanged; wrap <= 0.
//   - up may change on any cycle; the value sampled on the edge decides the
//     direction. No internal state beyond q and wrap.
//   - Reset mid-count overrides everything that edge. Pending wrap is cleared.
//   - Invalid internal nibbles (>9) cannot arise: reset and load are
//     sanitised, and the arithmetic only produces 0..9.
// CONFIGURATION
//   BCD_CNT_SAT_EN defined:
//     - Counter saturates instead of wrapping: up at all 9s holds all 9s;
//       down at 0 holds 0.
//     - wrap is instead a registered pulse meaning "saturation hit", asserted
//       for each cycle an enabled step was blocked.
//     - tc is unchanged.
//   BCD_CNT_SAT_EN undefined: wrap-around behaviour as above.
// TESTING (DIGITS=3, RESET_VAL=0)
//   1. rst_n=0 for 1 edge with en=1, up=1
//      -> q=12'h000, wrap=0; tc=0; q=12'h001 one edge after rst_n=1.
//   2. load din=12'h199, then en=1 up=1 for 1 edge
//      -> q=12'h200 (carry through two digits), wrap=0.
//   3. load 12'h999, en=1 up=1, 1 edge
//      -> tc=1 before the edge; q=12'h000, wrap=1 for 1 cycle then 0.
//      With BCD_CNT_SAT_EN: q=12'h999, wrap=1 while en held.
//   4. load 12'h000, en=1 up=0, 2 edges
//      -> q=12'h999 then 12'h998; wrap pulses once.
//   5. load=1 and en=1 together with din=12'h1A5
//      -> q=12'h195 (nibble clamped, no count step), wrap=0.
//   6. counting up from 12'h050, drop rst_n for 1 edge mid-run
//      -> q=12'h000 on that edge; counting resumes 12'h001, 12'h002 after
//      release.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//   Multi-digit synchronous BCD up/down counter with parallel load, count
//   enable, combinational terminal count and a registered wrap pulse.
//   Output q is packed BCD (digit 0 in [3:0]) so each nibble can feed a
//   7-segment decoder directly.
//
//   Optional build macro: BCD_CNT_SAT_EN
//     undefined (default) - counter wraps 999..9 -> 0 and 0 -> 999..9,
//                           wrap pulses for one cycle after each wrap.
//     defined             - counter saturates at the end of its range,
//                           wrap pulses for every cycle an enabled step
//                           was blocked by saturation.
//
//   Edge priority: rst_n low > load > en > hold.
module bcd_updown_counter #(
    parameter int                  DIGITS    = 3,
    parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap
);

    localparam int W = 4 * DIGITS;

    // Forces every nibble into 0..9 so no illegal BCD digit can ever be
    // stored; anything above 9 becomes 9.
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Reset value is also sanitised, so a badly chosen parameter cannot
    // seed the counter with an illegal digit.
    localparam logic [W-1:0] RESET_SAN = clamp_bcd(RESET_VAL);
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [W-1:0] din_san;
    logic [W-1:0] step_q;
    logic         carry;
    logic         is_nines;
    logic         is_zero;
    logic         at_limit;

    assign din_san  = clamp_bcd(din);
    assign is_nines = (q == ALL_NINES);
    assign is_zero  = (q == '0);

    // The current step would run off the end of the range in the
    // requested direction.
    assign at_limit = up ? is_nines : is_zero;

    // Terminal count depends only on q, en and up; it is not registered.
    assign tc = en & at_limit;

    // Ripple one +1 / -1 step through all digits in a single cycle. A digit
    // at 9 (up) or 0 (down) rolls over and passes the carry/borrow on; the
    // first digit that does not roll over absorbs it. Rolling over every
    // digit yields the natural wrap to 0 or to all nines.
    always_comb begin
        step_q = q;
        carry  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (up) begin
                    if (q[4*i +: 4] == 4'd9) begin
                        step_q[4*i +: 4] = 4'd0;
                    end else begin
                        step_q[4*i +: 4] = q[4*i +: 4] + 4'd1;
                        carry            = 1'b0;
                    end
                end else begin
                    if (q[4*i +: 4] == 4'd0) begin
                        step_q[4*i +: 4] = 4'd9;
                    end else begin
                        step_q[4*i +: 4] = q[4*i +: 4] - 4'd1;
                        carry            = 1'b0;
                    end
                end
            end
        end
    end

    // Count register and wrap pulse; wrap is cleared on every edge that
    // does not perform (or, when saturating, get blocked on) a limit step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= RESET_SAN;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= din_san;
            wrap <= 1'b0;
        end else if (en) begin
`ifdef BCD_CNT_SAT_EN
            if (at_limit) begin
                q    <= q;
                wrap <= 1'b1;
            end else begin
                q    <= step_q;
                wrap <= 1'b0;
            end
`else
            q    <= step_q;
            wrap <= at_limit;
`endif
        end else begin
            q    <= q;
            wrap <= 1'b0;
        end
    end

endmodule
